pc_next_unit: RTL
=================

# pc_next_unit

Parametrised program-counter generator for the IF stage; the successor of the fixed +4 PC incrementer. It holds the architectural fetch PC in a register and produces the sequential next PC with a selectable step of 2 or 4. It arbitrates trap, branch/jump redirect, stall and sequential advance, and buffers a redirect that arrives while IF is stalled. It feeds instruction memory and the IF/ID pipeline register.

## Interface
- XLEN, 32, address width in bits
- RESET_VEC, 32'h0000_0000, PC value loaded by reset
- C_EXT, 0, 1 enables 16-bit instruction step (+2) and 2-byte alignment

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit holds IF; PC must not advance
- compressed  in  1  current instruction is 16-bit; ignored when C_EXT=0
- redirect_valid  in  1  taken branch/jump from EX
- redirect_target  in  XLEN  redirect destination
- trap_valid  in  1  exception/trap redirect, highest priority
- trap_target  in  XLEN  trap handler address
- PC_out  out  XLEN  current fetch address (registered)
- inc_pc  out  XLEN  PC_out + step (combinational)
- fetch_valid  out  1  PC_out is a valid fetch address (registered)
- redirect_pending  out  1  a redirect is buffered, waiting for stall release
- misalign  out  1  one-cycle pulse: last applied target had masked low bits set

## Operation
- Step: 2 when C_EXT=1 and compressed=1, else 4. inc_pc = PC_out + step, modulo 2^XLEN (carry discarded).
- Alignment mask applied to every loaded target: C_EXT=1 clears bit 0; C_EXT=0 clears bits [1:0]. misalign is set on the load edge if any cleared bit was 1, and is cleared on the next edge.
- FSM states:
  - INIT: after reset.
  - RUN: advancing.
  - HOLD: stalled, nothing buffered.
  - HOLD_PEND: stalled with a buffered redirect.
- Transitions and PC update (rst=0), checked in priority order:
  1. trap_valid=1: PC <= aligned trap_target. Pending buffer is cleared. Next state is RUN if stall=0, else HOLD. Trap overrides stall.
  2. INIT: fetch_valid <= 1. PC is unchanged. Next state is RUN.
  3. stall=1 and redirect_valid=1: target is captured into the pending buffer, overwriting any older entry. PC is unchanged. Next state is HOLD_PEND.
  4. stall=1, no new redirect: PC and buffer are unchanged. Next state is HOLD, or HOLD_PEND if already pending.
  5. stall=0 and redirect_valid=1: PC <= aligned redirect_target. Buffer is cleared. Next state is RUN. A new redirect beats a pending one.
  6. stall=0, HOLD_PEND: PC <= aligned pending target. Buffer is cleared. Next state is RUN.
  7. stall=0 otherwise: PC <= inc_pc. Next state is RUN.
- redirect_pending = (state == HOLD_PEND).

## Timing
- Reset (rst=1 at edge):
  - PC_out = RESET_VEC.
  - fetch_valid = 0.
  - redirect_pending = 0.
  - misalign = 0.
  - State = INIT.
  - Reset overrides every other input, including mid-stall and mid-pending, where the buffer is discarded.
- First edge with rst=0 sets fetch_valid=1 and holds PC at RESET_VEC. Sequential advance begins on the following edge.
- Redirect latency is 1 cycle: target is visible on PC_out the cycle after the redirect_valid edge when stall=0.
- Buffered redirect: applied on the first edge where stall=0, so PC_out shows it 1 cycle after stall deasserts.
- inc_pc has zero latency from PC_out and compressed. There is no registered path.
- Simultaneous trap and redirect: trap wins and the redirect is dropped.
- Simultaneous stall release and new redirect: the new redirect wins over the pending one.

## Test plan
- Reset/sequence: XLEN=32, RESET_VEC=0x100. Assert rst 2 cycles, then release. PC_out=0x100 for 2 cycles (reset, INIT), then 0x104, 0x108. fetch_valid goes 0 then 1.
- Wrap and step: force PC=0xFFFF_FFFC, no stall. Next PC=0x0000_0000. With C_EXT=1 and compressed=1 from 0x200, expect 0x202, then 0x206 with compressed=0.
- Stall plus buffered redirect: at PC 0x40, stall=1 for 3 cycles with redirect 0x80 in cycle 1. PC holds 0x40 and redirect_pending=1. Stall drops: PC=0x80 the next cycle and pending=0.
- Priority: same edge trap 0x1000 plus redirect 0x80 plus stall=1. PC=0x1000, pending=0, state HOLD. After release, advance to 0x1004.
- Alignment: C_EXT=0, redirect 0x83. PC=0x80 and misalign pulses 1 cycle. C_EXT=1, redirect 0x83. PC=0x82 and misalign=1.
- Reset mid-pending: stall with pending 0x80, then rst=1. PC=RESET_VEC, pending=0. After release and stall drop, 0x80 is never loaded.

Source files
------------

// File: rtl/pc_next_if.sv
// Fetch-PC control bundle between the hazard/EX side and the IF-stage PC generator.
// The master drives stall and redirect requests; the slave returns the fetch PC and status.
interface pc_next_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            compressed;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            trap_valid;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] PC_out;
    logic [XLEN-1:0] inc_pc;
    logic            fetch_valid;
    logic            redirect_pending;
    logic            misalign;

    modport master (
        output stall, compressed, redirect_valid, redirect_target, trap_valid, trap_target,
        input  PC_out, inc_pc, fetch_valid, redirect_pending, misalign
    );

    modport slave (
        input  stall, compressed, redirect_valid, redirect_target, trap_valid, trap_target,
        output PC_out, inc_pc, fetch_valid, redirect_pending, misalign
    );
endinterface

// File: rtl/pc_next_unit.sv
// IF-stage program counter: sequential +2/+4 advance, trap and branch redirects,
// stall hold, and a one-entry buffer for a redirect that arrives while stalled.
module pc_next_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = {XLEN{1'b0}},
    parameter bit              C_EXT     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    pc_next_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_INIT      = 2'd0,
        ST_RUN       = 2'd1,
        ST_HOLD      = 2'd2,
        ST_HOLD_PEND = 2'd3
    } state_t;

    // Bits that must be zero in any loaded target.
    localparam logic [XLEN-1:0] LOW_MASK = C_EXT ? {{(XLEN-1){1'b0}}, 1'b1}
                                                 : {{(XLEN-2){1'b0}}, 2'b11};

    localparam logic [XLEN-1:0] STEP_2 = {{(XLEN-3){1'b0}}, 3'd2};
    localparam logic [XLEN-1:0] STEP_4 = {{(XLEN-3){1'b0}}, 3'd4};

    function automatic logic [XLEN-1:0] align_addr(input logic [XLEN-1:0] addr);
        return addr & ~LOW_MASK;
    endfunction

    function automatic logic low_bits_set(input logic [XLEN-1:0] addr);
        return |(addr & LOW_MASK);
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_nxt_s;
    logic [XLEN-1:0] pend_tgt_r;
    logic [XLEN-1:0] pend_tgt_nxt_s;
    logic            fetch_valid_r;
    logic            misalign_r;
    logic            misalign_nxt_s;
    logic [XLEN-1:0] step_s;
    logic [XLEN-1:0] inc_pc_s;

    // Sequential step size and successor address (carry out discarded).
    always_comb begin
        if (C_EXT && bus.compressed) begin
            step_s = STEP_2;
        end else begin
            step_s = STEP_4;
        end
        inc_pc_s = pc_r + step_s;
    end

    // Next-state and next-PC selection in priority order.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        pend_tgt_nxt_s = pend_tgt_r;
        misalign_nxt_s = 1'b0;
        if (bus.trap_valid) begin
            pc_nxt_s       = align_addr(bus.trap_target);
            misalign_nxt_s = low_bits_set(bus.trap_target);
            state_nxt_s    = bus.stall ? ST_HOLD : ST_RUN;
        end else if (state_r == ST_INIT) begin
            state_nxt_s = ST_RUN;
        end else if (bus.stall && bus.redirect_valid) begin
            pend_tgt_nxt_s = bus.redirect_target;
            state_nxt_s    = ST_HOLD_PEND;
        end else if (bus.stall) begin
            state_nxt_s = (state_r == ST_HOLD_PEND) ? ST_HOLD_PEND : ST_HOLD;
        end else if (bus.redirect_valid) begin
            pc_nxt_s       = align_addr(bus.redirect_target);
            misalign_nxt_s = low_bits_set(bus.redirect_target);
            state_nxt_s    = ST_RUN;
        end else if (state_r == ST_HOLD_PEND) begin
            pc_nxt_s       = align_addr(pend_tgt_r);
            misalign_nxt_s = low_bits_set(pend_tgt_r);
            state_nxt_s    = ST_RUN;
        end else begin
            pc_nxt_s    = inc_pc_s;
            state_nxt_s = ST_RUN;
        end
    end

    // State, PC and registered status; leaving HOLD_PEND is what discards the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_INIT;
            pc_r          <= RESET_VEC;
            pend_tgt_r    <= {XLEN{1'b0}};
            fetch_valid_r <= 1'b0;
            misalign_r    <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            pc_r          <= pc_nxt_s;
            pend_tgt_r    <= pend_tgt_nxt_s;
            fetch_valid_r <= 1'b1;
            misalign_r    <= misalign_nxt_s;
        end
    end

    assign bus.PC_out           = pc_r;
    assign bus.inc_pc           = inc_pc_s;
    assign bus.fetch_valid      = fetch_valid_r;
    assign bus.redirect_pending = (state_r == ST_HOLD_PEND);
    assign bus.misalign         = misalign_r;
endmodule
